// File: rtl/axis_downsize_pkg.sv
// -----------------------------------------------------------------------------
// axis_downsize_pkg
// Shared definitions for the transmit-side AXI4-Stream width reducer:
//   - holding-register state encoding (legacy-compatible constants + enum)
//   - segment count / index width helpers
//   - width legality check used by the top at elaboration
// No ports; imported by axis_downsize_tx and axis_seg_select.
// -----------------------------------------------------------------------------
package axis_downsize_pkg;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_SEND  = 1'b1;

  typedef enum logic [0:0] {
    EMPTY = ST_EMPTY,
    SEND  = ST_SEND
  } state_e;

  // Number of narrow segments carried by one wide beat.
  function automatic int seg_count(input int s, input int m);
    return s / m;
  endfunction

  // Width of the segment index; a single-segment build still needs one bit.
  function automatic int idx_width(input int seg);
    return (seg > 1) ? $clog2(seg) : 1;
  endfunction

  // Wide width must split into whole narrow beats made of whole bytes.
  function automatic bit widths_ok(input int s, input int m);
    return (m > 0) && (s >= m) && ((s % m) == 0) && ((m % 8) == 0);
  endfunction

endpackage

// File: rtl/axis_seg_select.sv
// -----------------------------------------------------------------------------
// axis_seg_select
// Combinational segment finder over a wide keep vector.
//   keep      : wide byte enables, SEG groups of M_KEEP_WIDTH bits
//   idx       : currently presented segment
//   next_idx  : lowest segment above idx with any keep bit set
//   has_next  : such a segment exists (idx is not the final segment)
//   first_idx : lowest segment with any keep bit set, 0 when keep is all zero
// -----------------------------------------------------------------------------
module axis_seg_select
  import axis_downsize_pkg::*;
#(
  parameter int SEG          = 4,
  parameter int M_KEEP_WIDTH = 2,
  parameter int IDX_W        = 2
) (
  input  logic [SEG*M_KEEP_WIDTH-1:0] keep,
  input  logic [IDX_W-1:0]            idx,
  output logic [IDX_W-1:0]            next_idx,
  output logic                        has_next,
  output logic [IDX_W-1:0]            first_idx
);

  logic [SEG-1:0] seg_nz;

  always_comb begin
    seg_nz = '0;
    for (int k = 0; k < SEG; k++) begin
      seg_nz[k] = |keep[k*M_KEEP_WIDTH +: M_KEEP_WIDTH];
    end
  end

  // Scan from the top down so the last hit is the lowest qualifying segment;
  // this skips any run of empty segments in a single step.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int k = SEG - 1; k >= 0; k--) begin
      if (seg_nz[k]) begin
        first_idx = IDX_W'(k);
      end
      if (seg_nz[k] && (k > int'(idx))) begin
        next_idx = IDX_W'(k);
        has_next = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_downsize_tx.sv
// -----------------------------------------------------------------------------
// axis_downsize_tx
// Transmit-side AXI4-Stream width reducer. One wide beat is held and emitted
// as narrow beats, lowest segment first; segments with an all-zero keep slice
// are skipped. tlast/tuser ride only on the final emitted segment. A wide beat
// whose keep is entirely zero still produces one narrow beat (segment 0,
// keep 0) so its tlast/tuser are not lost.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   s_axis_t{data,keep,valid,last,user}, s_axis_tready : wide slave side
//   m_axis_t{data,keep,valid,last,user}, m_axis_tready : narrow master side
//   busy                     : holding register occupied
// -----------------------------------------------------------------------------
module axis_downsize_tx
  import axis_downsize_pkg::*;
#(
  parameter int S_DATA_WIDTH = 64,
  parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
  parameter int M_DATA_WIDTH = 16,
  parameter int M_KEEP_WIDTH = M_DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 1
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,

  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,

  output logic                    busy
);

  localparam int SEG   = seg_count(S_DATA_WIDTH, M_DATA_WIDTH);
  localparam int IDX_W = idx_width(SEG);

  if (!widths_ok(S_DATA_WIDTH, M_DATA_WIDTH) ||
      (S_KEEP_WIDTH != SEG * M_KEEP_WIDTH)) begin : g_bad_widths
    $error("axis_downsize_tx: S_DATA_WIDTH must be a multiple of M_DATA_WIDTH, M_DATA_WIDTH a multiple of 8");
  end

  state_e                  state;
  logic [IDX_W-1:0]        idx;

  logic [S_DATA_WIDTH-1:0] data_p0;
  logic [S_KEEP_WIDTH-1:0] keep_p0;
  logic                    last_p0;
  logic [USER_WIDTH-1:0]   user_p0;

  logic [IDX_W-1:0]        next_idx;
  logic                    has_next;
  logic [IDX_W-1:0]        in_first_idx;
  logic [IDX_W-1:0]        cur_first_unused;
  logic [IDX_W-1:0]        in_next_unused;
  logic                    in_has_next_unused;

  logic                    final_seg;
  logic                    accept;
  logic                    advance;

  // Successor search over the held beat.
  axis_seg_select #(
    .SEG          (SEG),
    .M_KEEP_WIDTH (M_KEEP_WIDTH),
    .IDX_W        (IDX_W)
  ) u_cur_sel (
    .keep      (keep_p0),
    .idx       (idx),
    .next_idx  (next_idx),
    .has_next  (has_next),
    .first_idx (cur_first_unused)
  );

  // Starting segment of the incoming beat, so the first narrow beat after an
  // accept already points at a populated segment.
  axis_seg_select #(
    .SEG          (SEG),
    .M_KEEP_WIDTH (M_KEEP_WIDTH),
    .IDX_W        (IDX_W)
  ) u_in_sel (
    .keep      (s_axis_tkeep),
    .idx       ({IDX_W{1'b0}}),
    .next_idx  (in_next_unused),
    .has_next  (in_has_next_unused),
    .first_idx (in_first_idx)
  );

  assign busy      = (state == SEND);
  assign final_seg = busy && !has_next;
  assign advance   = busy && m_axis_tready;

  // Ready depends only on state, the final-segment flag and downstream ready;
  // the final segment leaving frees the holder in the same cycle.
  assign s_axis_tready = !rst && ((state == EMPTY) || (final_seg && m_axis_tready));
  assign accept        = s_axis_tvalid && s_axis_tready;

  // ---- stage p0: holding register (control) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      idx   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= SEND;
            idx   <= in_first_idx;
          end
        end
        SEND: begin
          if (advance) begin
            if (has_next) begin
              idx <= next_idx;
            end else if (accept) begin
              idx <= in_first_idx;
            end else begin
              state <= EMPTY;
              idx   <= '0;
            end
          end
        end
        default: begin
          state <= EMPTY;
          idx   <= '0;
        end
      endcase
    end
  end

  // ---- stage p0: holding register (data) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p0 <= s_axis_tdata;
      keep_p0 <= s_axis_tkeep;
      last_p0 <= s_axis_tlast;
      user_p0 <= s_axis_tuser;
    end
  end

  // ---- stage p0 -> master outputs ----
  // Outputs are selected straight from registers, so they cannot change while
  // a beat is stalled. Gating with busy keeps them at zero when nothing is
  // held, including right after reset when the data holder is undefined.
  always_comb begin
    m_axis_tvalid = busy;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    if (busy) begin
      m_axis_tdata = data_p0[int'(idx)*M_DATA_WIDTH +: M_DATA_WIDTH];
      m_axis_tkeep = keep_p0[int'(idx)*M_KEEP_WIDTH +: M_KEEP_WIDTH];
      if (final_seg) begin
        m_axis_tlast = last_p0;
        m_axis_tuser = user_p0;
      end
    end
  end

endmodule

// File: tb/tb_axis_downsize_tx.sv
// -----------------------------------------------------------------------------
// tb_axis_downsize_tx
// Directed, table-driven bench for axis_downsize_tx with default widths
// (64-bit in, 16-bit out). Single-beat frames come from a vector table;
// back-to-back, stall and reset cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_axis_downsize_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_axis_tdata  = '0;
  logic [7:0]  s_axis_tkeep  = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast  = 1'b0;
  logic [0:0]  s_axis_tuser  = '0;
  logic [15:0] m_axis_tdata;
  logic [1:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axis_downsize_tx dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy)
  );

  // One narrow beat packed as {data, keep, last, user}; beat j of a vector
  // sits at beats[j*20 +: 20].
  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    int          n;
    logic [79:0] beats;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [19:0] bt(input logic [15:0] d, input logic [1:0] k,
                                     input logic l, input logic u);
    return {d, k, l, u};
  endfunction

  function automatic logic [20:0] obs();
    return {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered just after a falling edge with the DUT idle.
  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    s_axis_tdata  = v.data;
    s_axis_tkeep  = v.keep;
    s_axis_tlast  = v.last;
    s_axis_tuser  = v.user;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    #1 chk($sformatf("vec%0d s_ready", i), s_axis_tready, 1);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    for (int j = 0; j < v.n; j++) begin
      #1 chk($sformatf("vec%0d beat%0d", i, j), obs(), {1'b1, v.beats[j*20 +: 20]});
      @(negedge clk);
    end
    #1 chk($sformatf("vec%0d idle", i), {m_axis_tvalid, busy}, 0);
  endtask

  task automatic seq_back_to_back();
    logic [15:0] d;
    s_axis_tdata  = 64'h4444_3333_2222_1111;
    s_axis_tkeep  = 8'hFF;
    s_axis_tlast  = 1'b1;
    s_axis_tuser  = 1'b0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      if (c == 1) s_axis_tdata = 64'h8888_7777_6666_5555;
      if (c == 5) s_axis_tvalid = 1'b0;
      #1;
      if (c < 8)
        chk($sformatf("b2b s_ready c%0d", c), s_axis_tready, (c == 0 || c == 4));
      if (c >= 1 && c <= 8) begin
        d = 16'(16'h1111 * c);
        chk($sformatf("b2b beat c%0d", c), obs(), {1'b1, bt(d, 2'b11, ((c - 1) % 4 == 3), 1'b0)});
      end
      if (c == 9)
        chk("b2b idle", {m_axis_tvalid, busy}, 0);
      @(negedge clk);
    end
  endtask

  task automatic seq_stall();
    int seg;
    logic [15:0] d;
    seg = 0;
    s_axis_tdata  = 64'h4444_3333_2222_1111;
    s_axis_tkeep  = 8'hFF;
    s_axis_tlast  = 1'b1;
    s_axis_tuser  = 1'b0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b0;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    for (int c = 0; c < 16 && seg < 4; c++) begin
      m_axis_tready = (c % 2 == 0);
      d = 16'(16'h1111 * (seg + 1));
      #1 chk($sformatf("stall c%0d", c), obs(), {1'b1, bt(d, 2'b11, (seg == 3), 1'b0)});
      if (m_axis_tready) seg++;
      @(negedge clk);
    end
    chk("stall all segments", seg, 4);
    #1 chk("stall idle", {m_axis_tvalid, busy}, 0);
    m_axis_tready = 1'b1;
  endtask

  task automatic seq_reset_mid();
    s_axis_tdata  = 64'h4444_3333_2222_1111;
    s_axis_tkeep  = 8'hFF;
    s_axis_tlast  = 1'b1;
    s_axis_tuser  = 1'b0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst at idx2 data", {m_axis_tvalid, m_axis_tdata}, {1'b1, 16'h3333});
    rst = 1'b1;
    #1 chk("rst s_ready low", s_axis_tready, 0);
    @(negedge clk);
    #1 chk("rst discards beat", {obs(), busy}, 0);
    chk("rst s_ready held low", s_axis_tready, 0);
    rst = 1'b0;
    #1 chk("rst release s_ready", s_axis_tready, 1);
    @(negedge clk);
    run_vec(0);
  endtask

  initial begin
    vecs[0] = '{data: 64'h4444_3333_2222_1111, keep: 8'hFF, last: 1'b1, user: 1'b0, n: 4,
                beats: {bt(16'h4444, 2'b11, 1'b1, 1'b0), bt(16'h3333, 2'b11, 1'b0, 1'b0),
                        bt(16'h2222, 2'b11, 1'b0, 1'b0), bt(16'h1111, 2'b11, 1'b0, 1'b0)}};
    vecs[1] = '{data: 64'hDDDD_0000_0000_AAAA, keep: 8'hC3, last: 1'b1, user: 1'b1, n: 2,
                beats: {40'h0, bt(16'hDDDD, 2'b11, 1'b1, 1'b1), bt(16'hAAAA, 2'b11, 1'b0, 1'b0)}};
    vecs[2] = '{data: 64'h0000_0000_0000_5A5A, keep: 8'h00, last: 1'b1, user: 1'b0, n: 1,
                beats: {60'h0, bt(16'h5A5A, 2'b00, 1'b1, 1'b0)}};
    vecs[3] = '{data: 64'h0000_BEEF_0000_0000, keep: 8'h30, last: 1'b0, user: 1'b1, n: 1,
                beats: {60'h0, bt(16'hBEEF, 2'b11, 1'b0, 1'b1)}};
    vecs[4] = '{data: 64'h8877_6655_4433_2211, keep: 8'h5A, last: 1'b0, user: 1'b0, n: 4,
                beats: {bt(16'h8877, 2'b01, 1'b0, 1'b0), bt(16'h6655, 2'b01, 1'b0, 1'b0),
                        bt(16'h4433, 2'b10, 1'b0, 1'b0), bt(16'h2211, 2'b10, 1'b0, 1'b0)}};
    vecs[5] = '{data: 64'hAB00_0000_0000_00CD, keep: 8'h81, last: 1'b1, user: 1'b0, n: 2,
                beats: {40'h0, bt(16'hAB00, 2'b10, 1'b1, 1'b0), bt(16'h00CD, 2'b01, 1'b0, 1'b0)}};

    repeat (3) @(negedge clk);
    #1 chk("reset outputs", {obs(), busy}, 0);
    chk("reset s_ready", s_axis_tready, 0);
    rst = 1'b0;
    #1 chk("post-reset s_ready", s_axis_tready, 1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_vec(i);
    end

    seq_back_to_back();
    seq_stall();
    seq_reset_mid();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
